// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter: state/owner encodings and IO address decode.
package mem_arbiter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } arb_owner_e;

    localparam logic [2:0] IC_FETCH_LEN = 3'd4;

    function automatic logic is_io_addr(input logic [1:0] addr_hi, input logic [1:0] io_sel);
        return addr_hi == io_sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational grant selection: LSB-first priority, IO-store gating and IC anti-starvation.
module mem_arbiter_arb_select
    import mem_arbiter_pkg::*;
#(
    parameter logic [2:0] STARVE_MAX = 3'd4,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic       i_ic_flag,
    input  logic       i_lsb_flag,
    input  logic       i_lsb_type,
    input  logic [1:0] i_lsb_addr_hi,
    input  logic       i_io_buffer_full,
    input  logic [2:0] i_starve_cnt,
    output logic       o_grant_ic,
    output logic       o_grant_lsb,
    output logic       o_io_blocked
);

    logic w_lsb_elig;
    logic w_ic_turn;

    assign o_io_blocked = i_lsb_flag && i_lsb_type && is_io_addr(i_lsb_addr_hi, IO_SEL)
                          && i_io_buffer_full;
    assign w_lsb_elig   = i_lsb_flag && !o_io_blocked;
    assign w_ic_turn    = i_starve_cnt >= STARVE_MAX;

    // IC wins when LSB is absent or LSB has already won STARVE_MAX times in a row.
    assign o_grant_ic  = i_ic_flag && (!w_lsb_elig || w_ic_turn);
    assign o_grant_lsb = w_lsb_elig && (!i_ic_flag || !w_ic_turn);

endmodule

// File: rtl/mem_arbiter.sv
// Single-request memory arbiter between ICache and LSB in front of the memory controller.
// Optional MEM_ARB_STATS_EN adds grant and IO-stall counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [1:0]  IO_SEL     = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll,
    input  logic        io_buffer_full,
    input  logic        IC_flag,
    input  logic [31:0] IC_addr,
    output logic        IC_commit,
    output logic [31:0] IC_data,
    input  logic        LSB_flag,
    input  logic        LSB_type,
    input  logic [31:0] LSB_addr,
    input  logic [2:0]  LSB_len,
    input  logic [31:0] LSB_data,
    output logic        LSB_commit,
    output logic [31:0] LSB_val,
    output logic        mc_flag,
    output logic        mc_type,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_data,
    input  logic        mc_commit,
    input  logic [31:0] mc_val
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_ic_grants,
    output logic [31:0] stat_lsb_grants,
    output logic [31:0] stat_io_stall
`endif
);

    localparam logic [2:0] STARVE_MAX_W = 3'(STARVE_MAX);

    arb_state_e  r_state, w_state_nxt;
    arb_owner_e  r_owner;
    logic [2:0]  r_starve_cnt, w_starve_nxt;
    logic        r_mc_flag, r_mc_type;
    logic [31:0] r_mc_addr, r_mc_data, r_ic_data, r_lsb_val;
    logic [2:0]  r_mc_len;

    logic w_grant_ic, w_grant_lsb, w_io_blocked;
    logic w_take_grant, w_mc_done, w_deliver;

    mem_arbiter_arb_select #(
        .STARVE_MAX (STARVE_MAX_W),
        .IO_SEL     (IO_SEL)
    ) u_arb_select (
        .i_ic_flag        (IC_flag),
        .i_lsb_flag       (LSB_flag),
        .i_lsb_type       (LSB_type),
        .i_lsb_addr_hi    (LSB_addr[17:16]),
        .i_io_buffer_full (io_buffer_full),
        .i_starve_cnt     (r_starve_cnt),
        .o_grant_ic       (w_grant_ic),
        .o_grant_lsb      (w_grant_lsb),
        .o_io_blocked     (w_io_blocked)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_take_grant = FALSE;
        w_mc_done    = FALSE;
        w_deliver    = FALSE;
        unique case (r_state)
            ARB_IDLE: begin
                if (!roll && (w_grant_ic || w_grant_lsb)) begin
                    w_take_grant = TRUE;
                    w_state_nxt  = ARB_BUSY;
                    if (w_grant_ic) begin
                        w_starve_nxt = 3'd0;
                    end else if (IC_flag && r_starve_cnt < STARVE_MAX_W) begin
                        w_starve_nxt = r_starve_cnt + 3'd1;
                    end
                end
            end
            ARB_BUSY: begin
                // A load hit by roll is dropped; a store always runs to completion.
                if (mc_commit) begin
                    w_mc_done = TRUE;
                    if (roll && !r_mc_type) begin
                        w_state_nxt = ARB_IDLE;
                    end else begin
                        w_deliver   = TRUE;
                        w_state_nxt = ARB_RESP;
                    end
                end else if (roll && !r_mc_type) begin
                    w_state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (mc_commit) begin
                    w_mc_done   = TRUE;
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_RESP: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_IC;
            r_starve_cnt <= 3'd0;
            r_mc_flag    <= FALSE;
            r_mc_type    <= FALSE;
            r_mc_addr    <= '0;
            r_mc_len     <= '0;
            r_mc_data    <= '0;
            r_ic_data    <= '0;
            r_lsb_val    <= '0;
        end else if (rdy) begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_take_grant) begin
                r_mc_flag <= TRUE;
                r_owner   <= w_grant_ic ? OWN_IC : OWN_LSB;
                r_mc_type <= w_grant_ic ? FALSE : LSB_type;
                r_mc_addr <= w_grant_ic ? IC_addr : LSB_addr;
                r_mc_len  <= w_grant_ic ? IC_FETCH_LEN : LSB_len;
                r_mc_data <= w_grant_ic ? 32'd0 : LSB_data;
            end else if (w_mc_done) begin
                r_mc_flag <= FALSE;
            end
            if (w_deliver) begin
                if (r_owner == OWN_IC) r_ic_data <= mc_val;
                else                   r_lsb_val <= mc_val;
            end
        end
    end

    assign mc_flag    = r_mc_flag;
    assign mc_type    = r_mc_type;
    assign mc_addr    = r_mc_addr;
    assign mc_len     = r_mc_len;
    assign mc_data    = r_mc_data;
    assign IC_data    = r_ic_data;
    assign LSB_val    = r_lsb_val;
    assign IC_commit  = rdy && (r_state == ARB_RESP) && (r_owner == OWN_IC);
    assign LSB_commit = rdy && (r_state == ARB_RESP) && (r_owner == OWN_LSB);

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_ic, r_stat_lsb, r_stat_io;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_ic  <= '0;
            r_stat_lsb <= '0;
            r_stat_io  <= '0;
        end else if (rdy) begin
            if (w_take_grant && w_grant_ic)  r_stat_ic  <= r_stat_ic + 32'd1;
            if (w_take_grant && w_grant_lsb) r_stat_lsb <= r_stat_lsb + 32'd1;
            if (r_state == ARB_IDLE && w_io_blocked) r_stat_io <= r_stat_io + 32'd1;
        end
    end

    assign stat_ic_grants  = r_stat_ic;
    assign stat_lsb_grants = r_stat_lsb;
    assign stat_io_stall   = r_stat_io;
`else
    logic w_unused_io_blocked;
    assign w_unused_io_blocked = w_io_blocked;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester/memory-controller agents plus a transaction-level
// reference model of grants, roll cancellation and commit timing.
module tb_mem_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam logic [1:0]  IO_SEL     = 2'b11;

    logic        clk = 1'b0;
    logic        rst, rdy, roll, io_buffer_full;
    logic        IC_flag, IC_commit;
    logic [31:0] IC_addr, IC_data;
    logic        LSB_flag, LSB_type, LSB_commit;
    logic [31:0] LSB_addr, LSB_data, LSB_val;
    logic [2:0]  LSB_len;
    logic        mc_flag, mc_type, mc_commit;
    logic [31:0] mc_addr, mc_data, mc_val;
    logic [2:0]  mc_len;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .IO_SEL     (IO_SEL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .roll           (roll),
        .io_buffer_full (io_buffer_full),
        .IC_flag        (IC_flag),
        .IC_addr        (IC_addr),
        .IC_commit      (IC_commit),
        .IC_data        (IC_data),
        .LSB_flag       (LSB_flag),
        .LSB_type       (LSB_type),
        .LSB_addr       (LSB_addr),
        .LSB_len        (LSB_len),
        .LSB_data       (LSB_data),
        .LSB_commit     (LSB_commit),
        .LSB_val        (LSB_val),
        .mc_flag        (mc_flag),
        .mc_type        (mc_type),
        .mc_addr        (mc_addr),
        .mc_len         (mc_len),
        .mc_data        (mc_data),
        .mc_commit      (mc_commit),
        .mc_val         (mc_val)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one outstanding request, a pending response slot, and the
    // count of consecutive LSB wins while IC was also asking.
    bit          m_req_valid, m_req_ic, m_type, m_cancel;
    int          m_resp;  // 0 none, 1 IC commit due, 2 LSB commit due
    int          m_streak;
    logic [31:0] m_addr, m_data, m_ic_data, m_lsb_val;
    logic [2:0]  m_len;

    // Agent state
    bit ic_done, lsb_done, mc_pending, mc_wait_low;
    int mc_delay;
    int p_rdy, p_roll, p_io, p_req, p_io_addr;

    task automatic model_reset();
        m_req_valid = 0; m_req_ic = 0; m_type = 0; m_cancel = 0;
        m_resp = 0; m_streak = 0;
        m_addr = '0; m_data = '0; m_len = '0; m_ic_data = '0; m_lsb_val = '0;
    endtask

    task automatic model_step();
        bit lsb_ok, ic_ok, pick_ic, pick_lsb;
        if (!rdy) return;
        if (m_resp != 0) begin
            m_resp = 0;
        end else if (m_req_valid) begin
            if (mc_commit) begin
                m_req_valid = 0;
                if (!m_cancel && !(roll && !m_type)) begin
                    if (m_req_ic) begin m_resp = 1; m_ic_data = mc_val; end
                    else          begin m_resp = 2; m_lsb_val = mc_val; end
                end
            end else if (roll && !m_type) begin
                m_cancel = 1;
            end
        end else if (!roll) begin
            lsb_ok = LSB_flag && !(LSB_type && LSB_addr[17:16] == IO_SEL && io_buffer_full);
            ic_ok  = IC_flag;
            pick_ic = 0; pick_lsb = 0;
            if (lsb_ok && ic_ok) begin
                if (m_streak < STARVE_MAX) begin pick_lsb = 1; m_streak++; end
                else                       begin pick_ic = 1; m_streak = 0; end
            end else if (ic_ok) begin
                pick_ic = 1; m_streak = 0;
            end else if (lsb_ok) begin
                pick_lsb = 1;
            end
            if (pick_ic) begin
                m_req_ic = 1; m_type = 0; m_addr = IC_addr; m_len = 3'd4; m_data = '0;
            end
            if (pick_lsb) begin
                m_req_ic = 0; m_type = LSB_type; m_addr = LSB_addr; m_len = LSB_len;
                m_data = LSB_data;
            end
            if (pick_ic || pick_lsb) begin m_req_valid = 1; m_cancel = 0; end
        end
    endtask

    task automatic check_outputs();
        check_eq("mc_flag", {31'b0, mc_flag}, {31'b0, m_req_valid});
        check_eq("mc_type", {31'b0, mc_type}, {31'b0, m_type});
        check_eq("mc_addr", mc_addr, m_addr);
        check_eq("mc_len", {29'b0, mc_len}, {29'b0, m_len});
        if (!m_req_ic) check_eq("mc_data", mc_data, m_data);
        check_eq("IC_commit", {31'b0, IC_commit}, {31'b0, rdy && m_resp == 1});
        check_eq("LSB_commit", {31'b0, LSB_commit}, {31'b0, rdy && m_resp == 2});
        check_eq("IC_data", IC_data, m_ic_data);
        check_eq("LSB_val", LSB_val, m_lsb_val);
    endtask

    task automatic clear_inputs();
        rdy = 1'b1; roll = 1'b0; io_buffer_full = 1'b0;
        IC_flag = 1'b0; IC_addr = '0;
        LSB_flag = 1'b0; LSB_type = 1'b0; LSB_addr = '0; LSB_len = '0; LSB_data = '0;
        mc_commit = 1'b0; mc_val = '0;
        ic_done = 0; lsb_done = 0; mc_pending = 0; mc_wait_low = 0; mc_delay = 0;
    endtask

    task automatic set_phase(input int cyc);
        if (cyc < 400) begin
            p_rdy = 100; p_roll = 0; p_io = 0;  p_req = 100; p_io_addr = 0;
        end else if (cyc < 2000) begin
            p_rdy = 85;  p_roll = 8; p_io = 40; p_req = 50;  p_io_addr = 50;
        end else if (cyc < 2600) begin
            p_rdy = 100; p_roll = 0; p_io = 30; p_req = 100; p_io_addr = 30;
        end else begin
            p_rdy = 90;  p_roll = 5; p_io = 80; p_req = 60;  p_io_addr = 70;
        end
    endtask

    task automatic drive_inputs();
        logic [31:0] a;
        rdy            = ($urandom_range(99) < p_rdy);
        roll           = ($urandom_range(99) < p_roll);
        io_buffer_full = ($urandom_range(99) < p_io);
        // ICache requester: drops after commit, abandons its fetch on roll
        if (ic_done) begin
            IC_flag = 1'b0; ic_done = 0;
        end else if (roll) begin
            IC_flag = 1'b0;
        end else if (!IC_flag && $urandom_range(99) < p_req) begin
            IC_flag = 1'b1; IC_addr = 32'($urandom) & 32'hFFFF_FFFC;
        end
        // LSB requester: stores survive roll, loads are abandoned
        if (lsb_done) begin
            LSB_flag = 1'b0; lsb_done = 0;
        end else if (roll && LSB_flag && !LSB_type) begin
            LSB_flag = 1'b0;
        end else if (!LSB_flag && $urandom_range(99) < p_req) begin
            a = 32'($urandom);
            if ($urandom_range(99) < p_io_addr) a[17:16] = IO_SEL;
            else                               a[17:16] = 2'($urandom_range(2));
            LSB_flag = 1'b1; LSB_type = 1'($urandom_range(1)); LSB_addr = a;
            LSB_data = 32'($urandom);
            case ($urandom_range(2))
                0:       LSB_len = 3'd1;
                1:       LSB_len = 3'd2;
                default: LSB_len = 3'd4;
            endcase
        end
        // Memory controller: responds after a random delay, only while rdy is high
        mc_commit = 1'b0;
        if (mc_pending) begin
            if (mc_delay == 0 && rdy) begin
                mc_commit = 1'b1; mc_val = 32'($urandom);
                mc_pending = 0; mc_wait_low = 1;
            end else if (mc_delay > 0) begin
                mc_delay--;
            end
        end
    endtask

    task automatic observe();
        if (IC_commit)  ic_done = 1;
        if (LSB_commit) lsb_done = 1;
        if (mc_wait_low && !mc_flag) mc_wait_low = 0;
        if (mc_flag && !mc_pending && !mc_wait_low) begin
            mc_pending = 1; mc_delay = $urandom_range(6);
        end
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_mc_flag", {31'b0, mc_flag}, 32'd0);
        check_eq("async_rst_mc_addr", mc_addr, 32'd0);
        check_eq("async_rst_mc_type", {31'b0, mc_type}, 32'd0);
        check_eq("async_rst_mc_len", {29'b0, mc_len}, 32'd0);
        check_eq("async_rst_mc_data", mc_data, 32'd0);
        check_eq("async_rst_IC_commit", {31'b0, IC_commit}, 32'd0);
        check_eq("async_rst_LSB_commit", {31'b0, LSB_commit}, 32'd0);
        check_eq("async_rst_IC_data", IC_data, 32'd0);
        check_eq("async_rst_LSB_val", LSB_val, 32'd0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit did_reset;
        did_reset = 0;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 3500; cyc++) begin
            @(negedge clk);
            set_phase(cyc);
            drive_inputs();
            #1;
            check_outputs();
            observe();
            model_step();
            if (!did_reset && cyc >= 1000 && mc_flag) begin
                async_reset_check();
                did_reset = 1;
            end
        end
        check_eq("async_reset_exercised", {31'b0, did_reset}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
